// File: rtl/axis_elastic_rx_static_32_pkg.sv
// Shared beat type and field widths for the 32-bit receive-side elastic buffer.
package lynxTypes;

  localparam int AXIS_32_DATA_BITS = 32;
  localparam int AXIS_32_KEEP_BITS = 4;

  typedef struct packed {
    logic [AXIS_32_DATA_BITS-1:0] tdata;
    logic [AXIS_32_KEEP_BITS-1:0] tkeep;
    logic                         tlast;
  } rx_beat_32_t;

  localparam int RX_BEAT_32_BITS = $bits(rx_beat_32_t);

endpackage

// File: rtl/axis_elastic_ram_32.sv
// Simple dual-port beat store: synchronous write, asynchronous read (maps to distributed RAM).
module axis_elastic_ram_32
  import lynxTypes::*;
#(
  parameter int ENTRIES = 7,
  parameter int ADDR_W  = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  rx_beat_32_t       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output rx_beat_32_t       rdata
);

  // No reset on the storage itself; validity is tracked entirely by the pointers.
  rx_beat_32_t mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_elastic_rx_static_32.sv
// Sink-side elastic buffer: output register plus DEPTH-1 entry circular array, all outputs registered.
module axis_elastic_rx_static_32
  import lynxTypes::*;
#(
  parameter int DEPTH    = 8,
  parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [AXIS_32_DATA_BITS-1:0] s_axis_tdata,
  input  logic [AXIS_32_KEEP_BITS-1:0] s_axis_tkeep,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [AXIS_32_DATA_BITS-1:0] m_axis_tdata,
  output logic [AXIS_32_KEEP_BITS-1:0] m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [CNT_BITS-1:0]          occupancy,
  output logic [CNT_BITS-1:0]          pkt_cnt,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W     = $clog2(DEPTH);
  localparam int ARR_DEPTH = DEPTH - 1;

  // Array is DEPTH-1 deep, so pointers wrap explicitly instead of overflowing.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ARR_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic               s_ready_reg, s_ready_next;
  logic               full_reg, full_next;
  logic               empty_reg, empty_next;
  logic               out_valid_reg, out_valid_next;
  rx_beat_32_t        out_beat_reg, out_beat_next;
  logic [CNT_BITS-1:0] count_reg, count_next;
  logic [CNT_BITS-1:0] pkt_reg, pkt_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;

  logic        push, pop, load_slot, arr_nonempty;
  logic        ram_re, ram_we, bypass;
  rx_beat_32_t in_beat, ram_rdata;

  assign in_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tlast};

  axis_elastic_ram_32 #(
    .ENTRIES(ARR_DEPTH),
    .ADDR_W (PTR_W)
  ) u_ram (
    .clk  (aclk),
    .we   (ram_we),
    .waddr(wr_ptr_reg),
    .wdata(in_beat),
    .raddr(rd_ptr_reg),
    .rdata(ram_rdata)
  );

  always_comb begin
    push         = s_axis_tvalid && s_ready_reg;
    pop          = out_valid_reg && m_axis_tready;
    load_slot    = !out_valid_reg || pop;
    arr_nonempty = (count_reg - CNT_BITS'(out_valid_reg)) != '0;

    // The array head has priority so ordering is preserved; bypass only when the array is empty.
    ram_re = load_slot && arr_nonempty;
    bypass = load_slot && !arr_nonempty && push;
    ram_we = push && !bypass;

    out_valid_next = out_valid_reg;
    out_beat_next  = out_beat_reg;
    if (ram_re) begin
      out_valid_next = 1'b1;
      out_beat_next  = ram_rdata;
    end else if (bypass) begin
      out_valid_next = 1'b1;
      out_beat_next  = in_beat;
    end else if (pop) begin
      out_valid_next = 1'b0;
    end

    wr_ptr_next = ram_we ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next = ram_re ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;

    count_next = count_reg + CNT_BITS'(push) - CNT_BITS'(pop);
    pkt_next   = pkt_reg + CNT_BITS'(push && s_axis_tlast)
                         - CNT_BITS'(pop && out_beat_reg.tlast);

    // Ready is computed from the post-edge count, so it is exact and never over-admits.
    s_ready_next = (count_next != CNT_BITS'(DEPTH));
    full_next    = (count_next == CNT_BITS'(DEPTH));
    empty_next   = (count_next == '0);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      s_ready_reg   <= 1'b0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      out_valid_reg <= 1'b0;
      out_beat_reg  <= '0;
      count_reg     <= '0;
      pkt_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      s_ready_reg   <= s_ready_next;
      full_reg      <= full_next;
      empty_reg     <= empty_next;
      out_valid_reg <= out_valid_next;
      out_beat_reg  <= out_beat_next;
      count_reg     <= count_next;
      pkt_reg       <= pkt_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
    end
  end

  assign s_axis_tready = s_ready_reg;
  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tdata  = out_beat_reg.tdata;
  assign m_axis_tkeep  = out_beat_reg.tkeep;
  assign m_axis_tlast  = out_beat_reg.tlast;
  assign occupancy     = count_reg;
  assign pkt_cnt       = pkt_reg;
  assign full          = full_reg;
  assign empty         = empty_reg;

endmodule

// File: tb/tb_axis_elastic_rx_static_32.sv
// Scoreboard bench for the 32-bit receive elastic buffer: directed vectors plus a negedge monitor.
module tb_axis_elastic_rx_static_32;

  localparam int DEPTH    = 8;
  localparam int CNT_BITS = 4;

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [CNT_BITS-1:0] occupancy;
  logic [CNT_BITS-1:0] pkt_cnt;
  logic        full;
  logic        empty;

  axis_elastic_rx_static_32 #(.DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .occupancy    (occupancy),
    .pkt_cnt      (pkt_cnt),
    .full         (full),
    .empty        (empty)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [36:0] sbq[$];
  int m_occ = 0;
  int m_pkt = 0;
  bit seen = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int max_occ = 0;

  always @(posedge aclk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks state against the model, then applies the handshakes that occur at the next edge.
  always @(negedge aclk) begin
    logic [36:0] exp_beat;
    if (!aresetn) begin
      sbq.delete();
      m_occ = 0;
      m_pkt = 0;
      seen  = 0;
    end else begin
      chk("occupancy", 64'(occupancy), 64'(m_occ));
      chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
      chk("s_tready", 64'(s_axis_tready), 64'(seen && m_occ != DEPTH));
      chk("full", 64'(full), 64'(m_occ == DEPTH));
      chk("empty", 64'(empty), 64'(m_occ == 0));
      chk("m_tvalid", 64'(m_axis_tvalid), 64'(m_occ != 0));
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (m_axis_tvalid && m_axis_tready) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected got %0h expected no beat at cycle %0d", m_axis_tdata, cyc);
        end else begin
          exp_beat = sbq.pop_front();
          chk("out_beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 64'(exp_beat));
          out_cnt++;
          m_occ--;
          if (exp_beat[0]) m_pkt--;
        end
      end
      if (s_axis_tvalid && s_axis_tready) begin
        sbq.push_back({s_axis_tdata, s_axis_tkeep, s_axis_tlast});
        acc_cnt++;
        m_occ++;
        if (s_axis_tlast) m_pkt++;
      end
      seen = 1;
    end
  end

  // Presents one beat from posedge+1 and holds it until accepted.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge aclk);
      acc = s_axis_tready && aresetn;
      @(posedge aclk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got no accept expected accept for data %0h", d);
    end
  endtask

  task automatic wait_drained(input int bound);
    int n;
    n = 0;
    while ((occupancy != 0 || sbq.size() != 0) && n < bound) begin
      @(posedge aclk);
      #1;
      n++;
    end
    chk("drain_done", 64'(n < bound), 64'(1));
  endtask

  bit a_done;
  int start_cyc;
  int left;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;

    // Reset then idle
    repeat (5) @(posedge aclk);
    #1;
    chk("rst_tready", 64'(s_axis_tready), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_occ", 64'(occupancy), 64'(0));
    chk("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    chk("rst_tdata", 64'(m_axis_tdata), 64'(0));
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    chk("rel_tready", 64'(s_axis_tready), 64'(1));
    chk("rel_tvalid", 64'(m_axis_tvalid), 64'(0));
    $display("reset: tready=%0d empty=%0d occ=%0d", s_axis_tready, empty, occupancy);

    // Single beat, one-cycle latency
    m_axis_tready = 1'b1;
    send_beat(32'hDEADBEEF, 4'hF, 1'b1);
    s_axis_tvalid = 1'b0;
    chk("single_tvalid", 64'(m_axis_tvalid), 64'(1));
    chk("single_tdata", 64'(m_axis_tdata), 64'hDEADBEEF);
    chk("single_tkeep", 64'(m_axis_tkeep), 64'hF);
    chk("single_tlast", 64'(m_axis_tlast), 64'(1));
    chk("single_pkt1", 64'(pkt_cnt), 64'(1));
    @(posedge aclk);
    #1;
    chk("single_pkt0", 64'(pkt_cnt), 64'(0));
    chk("single_gone", 64'(m_axis_tvalid), 64'(0));
    $display("single: data=deadbeef delivered, pkt_cnt back to %0d", pkt_cnt);

    // Fill: 10 beats offered with the sink stalled; tlast on beats 4, 8, 10
    m_axis_tready = 1'b0;
    acc_cnt = 0;
    out_cnt = 0;
    a_done = 0;
    fork
      begin
        for (int i = 1; i <= 10; i++) send_beat(32'(i), 4'hF, (i == 4 || i == 8 || i == 10));
        s_axis_tvalid = 1'b0;
        a_done = 1;
      end
    join_none
    repeat (12) @(posedge aclk);
    #1;
    chk("fill_accepted", 64'(acc_cnt), 64'(8));
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_occ", 64'(occupancy), 64'(8));
    chk("fill_tready", 64'(s_axis_tready), 64'(0));
    chk("fill_pkt", 64'(pkt_cnt), 64'(2));
    chk("fill_head", 64'(m_axis_tdata), 64'(1));
    $display("fill: accepted=%0d occ=%0d full=%0d", acc_cnt, occupancy, full);

    // Single pop from full: ready comes back on the following cycle
    m_axis_tready = 1'b1;
    @(posedge aclk);
    #1;
    m_axis_tready = 1'b0;
    chk("pop_occ", 64'(occupancy), 64'(7));
    chk("pop_tready", 64'(s_axis_tready), 64'(1));
    chk("pop_full", 64'(full), 64'(0));
    chk("pop_head", 64'(m_axis_tdata), 64'(2));
    @(posedge aclk);
    #1;
    chk("refill_occ", 64'(occupancy), 64'(8));
    $display("drain: one pop then refill, occ=%0d", occupancy);
    m_axis_tready = 1'b1;
    for (int n = 0; n < 100 && !a_done; n++) @(posedge aclk);
    #1;
    chk("fill_src_done", 64'(a_done), 64'(1));
    wait_drained(100);
    chk("fill_out_cnt", 64'(out_cnt), 64'(10));
    $display("drain: out_cnt=%0d in order", out_cnt);

    // Streaming: 1000 beats, random packet lengths 1..17
    max_occ = 0;
    out_cnt = 0;
    left = $urandom_range(1, 17);
    start_cyc = cyc;
    for (int i = 0; i < 1000; i++) begin
      send_beat($urandom, 4'($urandom_range(0, 15)), (left == 1));
      left--;
      if (left == 0) left = $urandom_range(1, 17);
    end
    chk("stream_cycles", 64'(cyc - start_cyc), 64'(1000));
    s_axis_tvalid = 1'b0;
    wait_drained(20);
    chk("stream_out_cnt", 64'(out_cnt), 64'(1000));
    chk("stream_max_occ", 64'(max_occ), 64'(1));
    $display("stream: 1000 beats in %0d cycles", 1000);

    // Random backpressure with a reset pulse in the middle of a packet
    a_done = 0;
    fork
      begin
        int l2;
        l2 = $urandom_range(1, 17);
        for (int i = 0; i < 200; i++) begin
          send_beat($urandom, 4'($urandom_range(0, 15)), (l2 == 1));
          l2--;
          if (l2 == 0) l2 = $urandom_range(1, 17);
        end
        s_axis_tvalid = 1'b0;
        a_done = 1;
      end
      begin
        while (!a_done) begin
          @(posedge aclk);
          #1;
          m_axis_tready = ($urandom_range(0, 99) < 30);
        end
      end
      begin
        repeat (60) @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid", 64'(m_axis_tvalid), 64'(0));
        chk("mid_rst_tready", 64'(s_axis_tready), 64'(0));
        chk("mid_rst_occ", 64'(occupancy), 64'(0));
        chk("mid_rst_pkt", 64'(pkt_cnt), 64'(0));
        chk("mid_rst_empty", 64'(empty), 64'(1));
        chk("mid_rst_tdata", 64'(m_axis_tdata), 64'(0));
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        chk("post_rst_occ", 64'(occupancy), 64'(0));
        $display("reset pulse: outputs cleared, occ=%0d", occupancy);
      end
    join
    m_axis_tready = 1'b1;
    wait_drained(100);
    chk("final_queue", 64'(sbq.size()), 64'(0));
    $display("backpressure: finished, final occ=%0d", occupancy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
